// File: rtl/regfile_write_arbiter_if.sv
// Write-request bus for regfile_write_arbiter: two requesters in, one register-file write port out.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter for a register file; x0 writes are suppressed.
// Define REGFILE_CLEAR_EN to zero all 32 registers after reset before accepting requests.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  logic              run;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy_o;

`ifdef REGFILE_CLEAR_EN
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned CLR_WORDS = 32;
  localparam logic [0:0]  ST_CLEAR  = 1'b0;
  localparam logic [0:0]  ST_RUN    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // Clear sequencer: one zero write per cycle, then a single idle cycle before RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_wr  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLR_WORDS)) begin
          state_d = ST_RUN;
        end else begin
          clr_wr = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  assign run      = (state_q == ST_RUN);
  assign clr_addr = ADDR_W'(cnt_q[4:0]);
  assign busy_o   = busy_q;
`else
  assign run      = 1'b1;
  assign clr_wr   = 1'b0;
  assign clr_addr = '0;
  assign busy_o   = 1'b0;
`endif

  logic              last_q, last_d;
  logic              grant0, grant1, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // last_q names the requester served most recently; the other one wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (run) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign xfer     = grant0 || grant1;
  assign sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

  // Next write-port values; address and data hold unless a real write is issued.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    if (clr_wr) begin
      wr_en_d   = 1'b1;
      wr_addr_d = clr_addr;
      wr_data_d = '0;
    end else if (xfer) begin
      last_d = grant1;
      if (sel_addr != '0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = sel_addr;
        wr_data_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b1;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_o;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus reset and clear sequences.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NV = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic          en;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs [NV];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
  endtask

  // Checks the zeroing sequence; optionally reasserts rst right after address abort_at.
  task automatic run_clear(input int abort_at);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("clr_en[%0d]", i), 32'(bus.wr_en), 32'd1);
      chk($sformatf("clr_addr[%0d]", i), 32'(bus.wr_addr), 32'(i));
      chk($sformatf("clr_data[%0d]", i), bus.wr_data, 32'd0);
      chk($sformatf("clr_busy[%0d]", i), 32'(bus.busy), 32'd1);
      chk($sformatf("clr_rdy[%0d]", i), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_clear_en", 32'(bus.wr_en), 32'd0);
        chk("rst_mid_clear_busy", 32'(bus.busy), 32'd1);
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("clr_done_busy", 32'(bus.busy), 32'd0);
    chk("clr_done_en", 32'(bus.wr_en), 32'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
`ifdef REGFILE_CLEAR_EN
    chk("rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    run_clear(-1);
`else
    chk("rst_busy", 32'(bus.busy), 32'd0);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_en", 32'(bus.wr_en), 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
`endif
  endtask

  initial begin
    //          v0    a0     d0             v1    a1     d1             r0    r1    en    ea     ed
    vecs[0]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0, 1'b1, 5'd3,  32'h11};
    vecs[1]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 5'd4,  32'h22};
    vecs[2]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b1, 1'b0, 1'b1, 5'd3,  32'h11};
    vecs[3]  = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       1'b0, 1'b1, 1'b1, 5'd4,  32'h22};
    vecs[4]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd7,  32'hAA,       1'b1, 5'd7,  32'hBB,       1'b1, 1'b0, 1'b1, 5'd7,  32'hAA};
    vecs[8]  = '{1'b1, 5'd7,  32'hAA,       1'b1, 5'd7,  32'hBB,       1'b0, 1'b1, 1'b1, 5'd7,  32'hBB};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h1234,     1'b0, 1'b1, 1'b1, 5'd9,  32'h1234};
    vecs[10] = '{1'b1, 5'd1,  32'h55,       1'b1, 5'd2,  32'h66,       1'b1, 1'b0, 1'b1, 5'd1,  32'h55};
    vecs[11] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd1,  32'h55};
    vecs[12] = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd11, 32'hB0,       1'b0, 1'b1, 1'b1, 5'd11, 32'hB0};
    vecs[13] = '{1'b0, 5'd10, 32'hA0,       1'b0, 5'd11, 32'hB0,       1'b0, 1'b0, 1'b0, 5'd11, 32'hB0};

    drive(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < int'(NV); i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d_ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      chk($sformatf("v%0d_ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].ea));
      chk($sformatf("v%0d_wr_data", i), bus.wr_data, vecs[i].ed);
    end

    // Leave the pointer at requester 0, then reset on a granting edge.
    drive(1'b1, 5'd2, 32'h42, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_addr", 32'(bus.wr_addr), 32'd2);
    rst = 1'b1;
    drive(1'b1, 5'd6, 32'h99, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_run_en", 32'(bus.wr_en), 32'd0);
    chk("rst_mid_run_addr", 32'(bus.wr_addr), 32'd0);
    do_reset();
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    #1;
    chk("ptr_reset_ready0", 32'(bus.req0_ready), 32'd1);
    chk("ptr_reset_ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("ptr_reset_addr", 32'(bus.wr_addr), 32'd3);
    drive(1'b0, '0, '0, 1'b0, '0, '0);

`ifdef REGFILE_CLEAR_EN
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_clear(12);
    rst = 1'b0;
    run_clear(-1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
